gcd_core: RTL and testbench

- Iterative greatest-common-divisor engine for two unsigned WIDTH-bit operands, using Euclid's algorithm by repeated subtraction.
- A one-cycle `start` pulse loads the operands; `done` rises when `result` holds gcd(a_in, b_in).
- Used as a standalone arithmetic accelerator driven by a simple start/done handshake from a controller or bench.

---
 rtl/gcd_core_if.sv | 42 ++++
 rtl/gcd_core.sv | 153 +++++++++++++++
 tb/tb_gcd_core.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_core_if.sv
// -----------------------------------------------------------------------------
// gcd_core_if
// Start/done handshake bundle for the gcd_core accelerator.
//
// Signals:
//   start   controller -> core   load request, sampled on rising clk
//   a_in    controller -> core   first operand, unsigned WIDTH bits
//   b_in    controller -> core   second operand, unsigned WIDTH bits
//   result  core -> controller   gcd of the last loaded pair, valid while done=1
//   done    core -> controller   registered level, 1 = result valid
//
// Modports:
//   master  the controller / bench side (drives start and operands)
//   slave   the gcd_core side (drives result and done)
// -----------------------------------------------------------------------------
interface gcd_core_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (
        output start,
        output a_in,
        output b_in,
        input  result,
        input  done
    );

    modport slave (
        input  start,
        input  a_in,
        input  b_in,
        output result,
        output done
    );

endinterface : gcd_core_if

// File: rtl/gcd_core.sv
// -----------------------------------------------------------------------------
// gcd_core
// Iterative greatest-common-divisor engine (Euclid by repeated subtraction)
// for two unsigned WIDTH-bit operands.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous reset, ACTIVE-HIGH despite its name
//   bus      gcd_core_if.slave: start, a_in, b_in in; result, done out
//
// Operation:
//   - A start edge (in any state) loads the operands, clears done and enters
//     RUN. result keeps its previous value until the new job finishes.
//   - In RUN the engine terminates as soon as either working register is zero
//     or both are equal; otherwise the larger register is reduced by the
//     smaller one. Because only larger-minus-smaller is ever taken, the
//     subtraction never wraps.
//   - In DONE, result and done hold until the next start edge or reset.
//   - All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module gcd_core #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    gcd_core_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Registered state and its next-state companions
    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_s;
    logic             done_r;
    logic             done_s;

    // Datapath status flags
    logic             a_zero_s;
    logic             b_zero_s;
    logic             a_eq_b_s;
    logic             a_gt_b_s;
    logic [WIDTH-1:0] diff_s;

    // Larger minus smaller; one shared subtractor serves both reduction
    // directions since only one of them is ever taken per cycle.
    function automatic logic [WIDTH-1:0] abs_diff(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] d;
        if (x > y) begin
            d = x - y;
        end else begin
            d = y - x;
        end
        return d;
    endfunction

    // Operand comparisons and the shared difference
    always_comb begin
        a_zero_s = (a_r == {WIDTH{1'b0}});
        b_zero_s = (b_r == {WIDTH{1'b0}});
        a_eq_b_s = (a_r == b_r);
        a_gt_b_s = (a_r > b_r);
        diff_s   = abs_diff(a_r, b_r);
    end

    // Next-state and next-output logic; a start edge overrides everything
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        result_s = result_r;
        done_s   = done_r;

        if (bus.start) begin
            // Load (or abort-and-reload): result intentionally untouched
            a_s     = bus.a_in;
            b_s     = bus.b_in;
            done_s  = 1'b0;
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_s = 1'b0;
                end

                ST_RUN: begin
                    // Zero checks come first so a zero operand terminates
                    // immediately instead of subtracting forever.
                    if (a_zero_s) begin
                        result_s = b_r;
                        done_s   = 1'b1;
                        state_s  = ST_DONE;
                    end else if (b_zero_s) begin
                        result_s = a_r;
                        done_s   = 1'b1;
                        state_s  = ST_DONE;
                    end else if (a_eq_b_s) begin
                        result_s = a_r;
                        done_s   = 1'b1;
                        state_s  = ST_DONE;
                    end else if (a_gt_b_s) begin
                        a_s = diff_s;
                    end else begin
                        b_s = diff_s;
                    end
                end

                ST_DONE: begin
                    done_s = 1'b1;
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet idle
                    state_s = ST_IDLE;
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    // State, working registers and output flops; reset is active-high
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_r  <= ST_IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            result_r <= result_s;
            done_r   <= done_s;
        end
    end

    assign bus.result = result_r;
    assign bus.done   = done_r;

endmodule : gcd_core

// File: tb/tb_gcd_core.sv
// -----------------------------------------------------------------------------
// tb_gcd_core
// Scoreboard bench for gcd_core: the driver pushes the expected gcd and
// latency of every job that should complete; a monitor pops and compares on
// each rising edge of done and checks that result holds while done stays high.
// -----------------------------------------------------------------------------
module tb_gcd_core;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] g;
        int           lat;
    } exp_t;

    logic   clk;
    logic   reset_n;
    int     n_checks;
    int     n_pass;
    int     cnt;
    logic   prev_done;
    logic [W-1:0] prev_result;
    logic [W-1:0] last_result;
    exp_t   q[$];

    gcd_core_if #(.WIDTH(W)) bus ();

    gcd_core #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference gcd via Euclid's remainder form
    function automatic logic [W-1:0] gcd_ref(input longint x, input longint y);
        longint t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[W-1:0];
    endfunction

    // Number of subtractions the repeated-subtraction algorithm performs,
    // computed in bulk with division rather than one step at a time.
    function automatic int ref_steps(input longint x, input longint y);
        longint k;
        int     s;
        s = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) begin
                k = (x % y == 0) ? (x / y - 1) : (x / y);
                x = x - k * y;
            end else begin
                k = (y % x == 0) ? (y / x - 1) : (y / x);
                y = y - k * x;
            end
            s = s + int'(k);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.g   = gcd_ref(longint'(a), longint'(b));
        e.lat = ref_steps(longint'(a), longint'(b)) + 1;
        q.push_back(e);
    endtask

    // One-cycle start pulse; push=0 for jobs that will be aborted
    task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        check("load_clears_done", {63'd0, bus.done}, 64'd0);
        check("load_keeps_result", {32'd0, bus.result}, {32'd0, last_result});
        if (push) push_exp(a, b);
    endtask

    task automatic wait_jobs(input int budget, input int idle);
        int i;
        i = 0;
        while (q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("job_done_in_budget", 64'(q.size()), 64'd0);
        repeat (idle) @(negedge clk);
    endtask

    // Edges since the last load edge
    always @(posedge clk or posedge reset_n) begin
        if (reset_n) cnt <= 0;
        else if (bus.start) cnt <= 0;
        else cnt <= cnt + 1;
    end

    // Monitor: compare on done rising, check hold while done stays high
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            prev_done   = 1'b0;
            prev_result = bus.result;
        end else begin
            if (bus.done && !prev_done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: result=%0h with no job outstanding (t=%0t)",
                             bus.result, $time);
                end else begin
                    e = q.pop_front();
                    check("result", {32'd0, bus.result}, {32'd0, e.g});
                    check("latency", 64'(cnt), 64'(e.lat));
                    last_result = e.g;
                end
            end else if (bus.done && prev_done) begin
                check("hold_result", {32'd0, bus.result}, {32'd0, prev_result});
            end
            prev_done   = bus.done;
            prev_result = bus.result;
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] base;
        n_checks    = 0;
        n_pass      = 0;
        last_result = '0;
        prev_done   = 1'b0;
        prev_result = '0;
        clk         = 1'b0;
        reset_n     = 1'b1;
        bus.start   = 1'b1;
        bus.a_in    = 'x;
        bus.b_in    = 'x;

        // Reset held ~1.5 cycles with start high and unknown operands
        #1;
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        #10;
        check("rst_done_2", {63'd0, bus.done}, 64'd0);
        check("rst_result_2", {32'd0, bus.result}, 64'd0);
        #6;
        reset_n  = 1'b0;
        bus.a_in = 32'd20;
        bus.b_in = 32'd45;
        @(negedge clk);
        bus.a_in = 32'd30;
        bus.b_in = 32'd45;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        push_exp(32'd30, 32'd45);
        wait_jobs(200, 2);

        // Directed jobs, each followed by a long hold window
        start_job(32'd12, 32'd8, 1'b1);                 wait_jobs(200, 10);
        start_job(32'd17, 32'd5, 1'b1);                 wait_jobs(200, 3);
        start_job(32'd48, 32'd18, 1'b1);                wait_jobs(200, 3);
        start_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);  wait_jobs(200, 3);
        start_job(32'd0, 32'd9, 1'b1);                  wait_jobs(200, 3);
        start_job(32'd9, 32'd0, 1'b1);                  wait_jobs(200, 3);
        start_job(32'd0, 32'd0, 1'b1);                  wait_jobs(200, 3);

        // Abort a long job with a new start two cycles into RUN
        start_job(32'd1000, 32'd1, 1'b0);
        repeat (2) @(negedge clk);
        start_job(32'd48, 32'd18, 1'b1);
        wait_jobs(200, 3);

        // Asynchronous reset in the middle of a long job
        start_job(32'd1000, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("midrun_rst_done", {63'd0, bus.done}, 64'd0);
        check("midrun_rst_result", {32'd0, bus.result}, 64'd0);
        last_result = '0;
        @(negedge clk);
        reset_n = 1'b0;
        start_job(32'd21, 32'd14, 1'b1);
        wait_jobs(200, 3);

        // Randomized jobs: small operands and scaled multiples of a common base
        for (int j = 0; j < 24; j++) begin
            if (j % 2 == 0) begin
                ra = W'($urandom_range(0, 400));
                rb = W'($urandom_range(0, 400));
            end else begin
                base = W'($urandom_range(1, 1 << 20));
                ra   = base * W'($urandom_range(1, 200));
                rb   = base * W'($urandom_range(1, 200));
            end
            start_job(ra, rb, 1'b1);
            wait_jobs(2000, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gcd_core
